// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the Hamming SECDED code family.
// A code word is N = DATA_W + P_W + 1 bits: bit 0 is overall (even) parity,
// power-of-two positions hold Hamming parity, and data fills the rest in order.
package hamming_pkg;

    // Outcome of decoding one word.
    typedef enum logic [1:0] {
        CLEAN  = 2'd0,
        CORR   = 2'd1,
        UNCORR = 2'd2
    } err_class_t;

    // True when k is a power of two, i.e. a Hamming parity position.
    function automatic bit is_pow2(input int k);
        return (k > 0) && ((k & (k - 1)) == 0);
    endfunction

    // Smallest p with 2^p >= data_w + p + 1.
    function automatic int calc_p_w(input int data_w);
        int p;
        p = 1;
        while ((2 ** p) < (data_w + p + 1)) p = p + 1;
        return p;
    endfunction

    // Code position that carries data bit idx (data[0] sits at position 3).
    function automatic int data_to_pos(input int idx);
        int pos;
        int cnt;
        pos = 3;
        cnt = 0;
        while (cnt < idx) begin
            pos = pos + 1;
            if (!is_pow2(pos)) cnt = cnt + 1;
        end
        return pos;
    endfunction

    // Data index carried by a non-power-of-two code position.
    function automatic int pos_to_data(input int pos);
        int idx;
        idx = 0;
        for (int k = 3; k < pos; k++) begin
            if (!is_pow2(k)) idx = idx + 1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/hamming_secded_dec_if.sv
// Streaming interface of the SECDED decoder: a code-word input channel and a
// decoded-result output channel, both valid/ready. The decoder uses the slave
// modport; the producer/consumer side uses master.
interface hamming_secded_dec_if #(
    parameter int DATA_W = 4
);
    import hamming_pkg::*;

    localparam int P_W = calc_p_w(DATA_W);
    localparam int N   = DATA_W + P_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_code;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err_corr;
    logic              out_err_uncorr;
    logic [P_W-1:0]    out_syndrome;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_err_corr, out_err_uncorr, out_syndrome
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_err_corr, out_err_uncorr, out_syndrome
    );

endinterface

// File: rtl/hamming_syndrome.sv
// Purely combinational syndrome and overall-parity calculation for an N-bit
// SECDED code word. Shared with the matching encoder.
module hamming_syndrome #(
    parameter int N   = 8,
    parameter int P_W = 3
) (
    input  logic [N-1:0]   i_code,
    output logic [P_W-1:0] o_syndrome,
    output logic           o_ovr
);

    // Syndrome is the XOR of the indices of every set bit in positions 1..N-1.
    // NOTE: every always_comb target gets a default before any conditional update,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_syndrome = '0;
        for (int k = 1; k < N; k++) begin
            if (i_code[k]) o_syndrome = o_syndrome ^ P_W'(k);
        end
    end

    assign o_ovr = ^i_code;

endmodule

// File: rtl/hamming_secded_dec.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready on both sides.
// Stage 1 registers the word, syndrome and overall parity; stage 2 registers
// the corrected payload, error flags and syndrome.
// Optional feature: define HAMMING_ERR_CNT_EN to build the saturating error
// counters; otherwise cnt_corr/cnt_uncorr read 0 and cnt_clr is ignored.
module hamming_secded_dec
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hamming_secded_dec_if.slave bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_uncorr
);

    localparam int P_W = calc_p_w(DATA_W);
    localparam int N   = DATA_W + P_W + 1;

    logic              w_adv;
    logic [P_W-1:0]    w_syn;
    logic              w_ovr;

    logic              r_s1_valid;
    logic [N-1:0]      r_s1_code;
    logic [P_W-1:0]    r_s1_syn;
    logic              r_s1_ovr;

    err_class_t        w_class;
    logic              w_flip;
    logic [N-1:0]      w_fixed;
    logic [DATA_W-1:0] w_data;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_err_corr;
    logic              r_out_err_uncorr;
    logic [P_W-1:0]    r_out_syndrome;

    // Parity positions are only needed for the syndrome, not for extraction.
    logic              w_unused_code;
    assign w_unused_code = ^r_s1_code;

    // The whole pipe moves whenever the output register is free or draining.
    // During reset out_valid is 0, so in_ready reads 1.
    assign w_adv        = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    hamming_syndrome #(
        .N   (N),
        .P_W (P_W)
    ) u_syndrome (
        .i_code     (bus.in_code),
        .o_syndrome (w_syn),
        .o_ovr      (w_ovr)
    );

    // Stage 1: capture the received word, its syndrome and overall parity.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
            r_s1_ovr   <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= bus.in_valid;
            r_s1_code  <= bus.in_code;
            r_s1_syn   <= w_syn;
            r_s1_ovr   <= w_ovr;
        end
    end

    // Classify the stage-1 word and flip the erroneous position if correctable.
    always_comb begin
        w_class = CLEAN;
        w_flip  = 1'b0;
        if (r_s1_syn == '0) begin
            if (r_s1_ovr) w_class = CORR;  // only the overall parity bit is wrong
        end else if (r_s1_ovr && (32'(r_s1_syn) <= 32'(N - 1))) begin
            w_class = CORR;
            w_flip  = 1'b1;
        end else begin
            w_class = UNCORR;
        end
        w_fixed = r_s1_code;
        if (w_flip) w_fixed = r_s1_code ^ (N'(1) << r_s1_syn);
    end

    // Gather the payload from the non-power-of-two positions.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_extract
        localparam int POS = data_to_pos(gi);
        assign w_data[gi] = w_fixed[POS];
    end

    // Stage 2: register the decoded result; it holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid      <= 1'b0;
            r_out_data       <= '0;
            r_out_err_corr   <= 1'b0;
            r_out_err_uncorr <= 1'b0;
            r_out_syndrome   <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data       <= w_data;
                r_out_err_corr   <= (w_class == CORR);
                r_out_err_uncorr <= (w_class == UNCORR);
                r_out_syndrome   <= r_s1_syn;
            end
        end
    end

    assign bus.out_valid      = r_out_valid;
    assign bus.out_data       = r_out_data;
    assign bus.out_err_corr   = r_out_err_corr;
    assign bus.out_err_uncorr = r_out_err_uncorr;
    assign bus.out_syndrome   = r_out_syndrome;

`ifdef HAMMING_ERR_CNT_EN
    logic             w_out_hs;
    logic [CNT_W-1:0] r_cnt_corr;
    logic [CNT_W-1:0] r_cnt_uncorr;

    assign w_out_hs = r_out_valid && bus.out_ready;

    // Saturating error counters, bumped on the output handshake; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_corr   <= '0;
            r_cnt_uncorr <= '0;
        end else if (cnt_clr) begin
            r_cnt_corr   <= '0;
            r_cnt_uncorr <= '0;
        end else if (w_out_hs) begin
            if (r_out_err_corr && (r_cnt_corr != '1))
                r_cnt_corr <= r_cnt_corr + CNT_W'(1);
            if (r_out_err_uncorr && (r_cnt_uncorr != '1))
                r_cnt_uncorr <= r_cnt_uncorr + CNT_W'(1);
        end
    end

    assign cnt_corr   = r_cnt_corr;
    assign cnt_uncorr = r_cnt_uncorr;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign cnt_corr         = '0;
    assign cnt_uncorr       = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Directed testbench for hamming_secded_dec at DATA_W=4 (N=8) and CNT_W=2.
// Expected values are hand-computed code words; counter expectations follow
// whether HAMMING_ERR_CNT_EN is defined for the build.
module tb_hamming_secded_dec;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 2;

`ifdef HAMMING_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_corr;
    logic [CNT_W-1:0] cnt_uncorr;

    int n_checks;
    int n_fail;

    hamming_secded_dec_if #(.DATA_W(DATA_W)) bus ();

    hamming_secded_dec #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cnt_clr    (cnt_clr),
        .cnt_corr   (cnt_corr),
        .cnt_uncorr (cnt_uncorr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single cycle; caller guarantees in_ready=1.
    task automatic send_code(input logic [7:0] code);
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input int data, input int corr,
                             input int uncorr, input int syn);
        check({tag, ".valid"},  32'(bus.out_valid), 1);
        check({tag, ".data"},   32'(bus.out_data), data);
        check({tag, ".corr"},   32'(bus.out_err_corr), corr);
        check({tag, ".uncorr"}, 32'(bus.out_err_uncorr), uncorr);
        check({tag, ".syn"},    32'(bus.out_syndrome), syn);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.out_ready = 1'b1;
        cnt_clr       = 1'b0;
        rst_n         = 1'b0;

        // Reset state
        #2;
        check("rst.in_ready",   32'(bus.in_ready), 1);
        check("rst.out_valid",  32'(bus.out_valid), 0);
        check("rst.out_data",   32'(bus.out_data), 0);
        check("rst.corr",       32'(bus.out_err_corr), 0);
        check("rst.uncorr",     32'(bus.out_err_uncorr), 0);
        check("rst.syn",        32'(bus.out_syndrome), 0);
        check("rst.cnt_corr",   32'(cnt_corr), 0);
        check("rst.cnt_uncorr", 32'(cnt_uncorr), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean word 0x66 -> data 0110, two-cycle latency
        send_code(8'h66);
        check("clean.lat1.valid", 32'(bus.out_valid), 0);
        tick();
        check_out("clean", 'h6, 0, 0, 0);
        tick();
        check("clean.bubble", 32'(bus.out_valid), 0);
        check("clean.cnt_corr", 32'(cnt_corr), 0);

        // Position 5 flipped
        send_code(8'h46);
        tick();
        check_out("pos5", 'h6, 1, 0, 5);
        tick();
        check("pos5.cnt_corr", 32'(cnt_corr), CNT_EN ? 1 : 0);

        // Overall parity bit flipped
        send_code(8'h67);
        tick();
        check_out("bit0", 'h6, 1, 0, 0);
        tick();
        check("bit0.cnt_corr", 32'(cnt_corr), CNT_EN ? 2 : 0);

        // Positions 5 and 6 flipped: double error
        send_code(8'h06);
        tick();
        check_out("dbl", 'h0, 0, 1, 3);
        tick();
        check("dbl.cnt_uncorr", 32'(cnt_uncorr), CNT_EN ? 1 : 0);
        check("dbl.cnt_corr",   32'(cnt_corr), CNT_EN ? 2 : 0);

        // Counter clear
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr.cnt_corr",   32'(cnt_corr), 0);
        check("clr.cnt_uncorr", 32'(cnt_uncorr), 0);

        // Five corrected words back-to-back: 2-bit counter saturates at 3
        bus.in_valid = 1'b1;
        bus.in_code  = 8'h46;
        repeat (5) tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check("sat.cnt_corr",   32'(cnt_corr), CNT_EN ? 3 : 0);
        check("sat.cnt_uncorr", 32'(cnt_uncorr), 0);

        // Clear coinciding with a counted handshake: clear wins
        send_code(8'h46);
        tick();
        check("clrhs.valid", 32'(bus.out_valid), 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clrhs.cnt_corr", 32'(cnt_corr), 0);

        // Back-pressure: 0x0F (0001), 0xFF (1111), 0xA5 (1010) with out_ready=0
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_code   = 8'h0F;
        tick();
        check("bp.in_ready_open", 32'(bus.in_ready), 1);
        bus.in_code = 8'hFF;
        tick();
        bus.in_code = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            check("bp.hold.in_ready", 32'(bus.in_ready), 0);
            check_out("bp.hold", 'h1, 0, 0, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp.release.in_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        check_out("bp.w1", 'hF, 0, 0, 0);
        tick();
        check_out("bp.w2", 'hA, 0, 0, 0);
        tick();
        check("bp.drained", 32'(bus.out_valid), 0);

        // Reset with two words in flight
        send_code(8'h46);
        tick();
        tick();
        check("prerst.cnt_corr", 32'(cnt_corr), CNT_EN ? 1 : 0);
        bus.in_valid = 1'b1;
        bus.in_code  = 8'h66;
        tick();
        tick();
        check("prerst.valid", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 32'(bus.out_valid), 0);
        check("midrst.cnt_corr",  32'(cnt_corr), 0);
        check("midrst.in_ready",  32'(bus.in_ready), 1);
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        send_code(8'h66);
        check("postrst.lat1", 32'(bus.out_valid), 0);
        tick();
        check_out("postrst", 'h6, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
